// File: rtl/gcu_pkg.sv
// Shared types for the GCU ready dispatcher: node/count widths, request kind, stage payload.
package gcu_pkg;

  localparam int GCU_NODE_ID_W   = 16;
  localparam int GCU_CHILD_CNT_W = 16;

  typedef logic [GCU_NODE_ID_W-1:0]   node_id_t;
  typedef logic [GCU_CHILD_CNT_W-1:0] child_cnt_t;

  typedef enum logic {
    REQ_INIT    = 1'b0,
    REQ_SCATTER = 1'b1
  } req_kind_e;

  typedef struct packed {
    logic       valid;
    req_kind_e  kind;
    node_id_t   node_id;
    node_id_t   child_id;
    child_cnt_t count;
  } stage_t;

endpackage

// File: rtl/gcu_rr_arbiter.sv
// One-hot round-robin arbiter with grant enable; combinational grant, pointer advances past the winner.
// No grant (and no pointer move) while en is low.
module gcu_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   probe;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    probe   = '0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      probe = {1'b0, ptr} + (IW+1)'(i);
      if (probe >= (IW+1)'(N)) probe = probe - (IW+1)'(N);
      sel = probe[IW-1:0];
      if (!found && req[sel]) begin
        found   = 1'b1;
        gnt_idx = sel;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/gcu_ready_dispatcher.sv
// Arbitrates loader inits and scatter-done events into the scoreboard, detects ready nodes, queues them.
// Accept-to-disp_valid is 3 cycles; requests are only granted while FIFO credit covers every in-flight stage.
module gcu_ready_dispatcher
  import gcu_pkg::*;
#(
  parameter int NODE_ID_W   = GCU_NODE_ID_W,
  parameter int CHILD_CNT_W = GCU_CHILD_CNT_W,
  parameter int NUM_SCAT    = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [NODE_ID_W-1:0]            ld_node_id,
  input  logic [CHILD_CNT_W-1:0]          ld_children_count,
  input  logic [NUM_SCAT-1:0]             sc_valid,
  output logic [NUM_SCAT-1:0]             sc_ready,
  input  logic [NUM_SCAT*NODE_ID_W-1:0]   sc_child_id,
  input  logic [NUM_SCAT*NODE_ID_W-1:0]   sc_parent_id,
  output logic                            sb_init_valid,
  output logic [NODE_ID_W-1:0]            sb_init_node_id,
  output logic [CHILD_CNT_W-1:0]          sb_init_children_count,
  output logic                            sb_scatter_done_valid,
  output logic [NODE_ID_W-1:0]            sb_scatter_done_child_id,
  output logic [NODE_ID_W-1:0]            sb_scatter_done_parent_id,
  output logic [NODE_ID_W-1:0]            sb_query_node_id,
  input  logic                            sb_front_ready,
  output logic                            disp_valid,
  input  logic                            disp_ready,
  output logic [NODE_ID_W-1:0]            disp_node_id,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            idle
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int SIW = (NUM_SCAT > 1) ? $clog2(NUM_SCAT) : 1;

  stage_t         s1;
  logic           s2_valid;
  req_kind_e      s2_kind;
  node_id_t       s2_node_id;
  logic           s2_zero;

  logic [CW:0]    occupied;
  logic           has_credit;
  logic           ld_fire;
  logic           sc_fire;
  logic [SIW-1:0] sc_idx;
  logic           push;
  logic           pop;
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  node_id_t       mem [FIFO_DEPTH];

  // Entries already in the FIFO plus everything in S1/S2 that could still push.
  assign occupied   = {1'b0, fifo_count} + {{CW{1'b0}}, s1.valid} + {{CW{1'b0}}, s2_valid};
  assign has_credit = occupied < (CW+1)'(FIFO_DEPTH);
  assign ld_ready   = has_credit;
  assign ld_fire    = ld_valid & has_credit;
  assign sc_fire    = |sc_ready;

  gcu_rr_arbiter #(.N(NUM_SCAT)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (sc_valid),
    .en      (has_credit & ~ld_valid),
    .gnt     (sc_ready),
    .gnt_idx (sc_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= ld_fire | sc_fire;
      if (ld_fire) begin
        s1.kind     <= REQ_INIT;
        s1.node_id  <= ld_node_id;
        s1.child_id <= '0;
        s1.count    <= ld_children_count;
      end else if (sc_fire) begin
        s1.kind     <= REQ_SCATTER;
        s1.node_id  <= sc_parent_id[sc_idx*NODE_ID_W +: NODE_ID_W];
        s1.child_id <= sc_child_id[sc_idx*NODE_ID_W +: NODE_ID_W];
        s1.count    <= '0;
      end
    end
  end

  assign sb_init_valid             = s1.valid & (s1.kind == REQ_INIT);
  assign sb_init_node_id           = s1.node_id;
  assign sb_init_children_count    = s1.count;
  assign sb_scatter_done_valid     = s1.valid & (s1.kind == REQ_SCATTER);
  assign sb_scatter_done_child_id  = s1.child_id;
  assign sb_scatter_done_parent_id = s1.node_id;

  // Payload is only reloaded on a valid S1 so the query id holds while S2 is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_kind    <= REQ_INIT;
      s2_node_id <= '0;
      s2_zero    <= 1'b0;
    end else begin
      s2_valid <= s1.valid;
      if (s1.valid) begin
        s2_kind    <= s1.kind;
        s2_node_id <= s1.node_id;
        s2_zero    <= (s1.count == '0);
      end
    end
  end

  assign sb_query_node_id = s2_node_id;
  assign push = s2_valid & ((s2_kind == REQ_SCATTER) ? sb_front_ready : s2_zero);
  assign pop  = disp_valid & disp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s2_node_id;
  end

  assign fifo_count   = wr_ptr - rd_ptr;
  assign disp_valid   = (fifo_count != '0);
  assign disp_node_id = disp_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign idle         = ~s1.valid & ~s2_valid & (fifo_count == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_gcu_ready_dispatcher.sv
// Scoreboard bench for gcu_ready_dispatcher with a behavioural dependency-scoreboard model.
module tb_gcu_ready_dispatcher;
  import gcu_pkg::*;

  localparam int NW  = 16;
  localparam int CCW = 16;
  localparam int NS  = 4;
  localparam int FD  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_valid;
  logic              ld_ready;
  logic [NW-1:0]     ld_node_id;
  logic [CCW-1:0]    ld_children_count;
  logic [NS-1:0]     sc_valid;
  logic [NS-1:0]     sc_ready;
  logic [NS*NW-1:0]  sc_child_id;
  logic [NS*NW-1:0]  sc_parent_id;
  logic              sb_init_valid;
  logic [NW-1:0]     sb_init_node_id;
  logic [CCW-1:0]    sb_init_children_count;
  logic              sb_scatter_done_valid;
  logic [NW-1:0]     sb_scatter_done_child_id;
  logic [NW-1:0]     sb_scatter_done_parent_id;
  logic [NW-1:0]     sb_query_node_id;
  logic              sb_front_ready;
  logic              disp_valid;
  logic              disp_ready;
  logic [NW-1:0]     disp_node_id;
  logic [$clog2(FD):0] fifo_count;
  logic              idle;

  always #5 clk = ~clk;

  gcu_ready_dispatcher #(.NODE_ID_W(NW), .CHILD_CNT_W(CCW), .NUM_SCAT(NS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_node_id(ld_node_id),
    .ld_children_count(ld_children_count),
    .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_child_id(sc_child_id), .sc_parent_id(sc_parent_id),
    .sb_init_valid(sb_init_valid), .sb_init_node_id(sb_init_node_id),
    .sb_init_children_count(sb_init_children_count),
    .sb_scatter_done_valid(sb_scatter_done_valid),
    .sb_scatter_done_child_id(sb_scatter_done_child_id),
    .sb_scatter_done_parent_id(sb_scatter_done_parent_id),
    .sb_query_node_id(sb_query_node_id), .sb_front_ready(sb_front_ready),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_node_id(disp_node_id),
    .fifo_count(fifo_count), .idle(idle)
  );

  int checks = 0;
  int passes = 0;
  int disp_seen = 0;
  node_id_t exp_q[$];
  logic [15:0] exp_cnt [0:255];

  // Dependency scoreboard model: counts update at the clock edge, front_ready is combinational.
  logic [15:0] sbm_cnt [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sbm_cnt[i] <= '0;
    end else begin
      if (sb_init_valid) sbm_cnt[sb_init_node_id[7:0]] <= sb_init_children_count;
      if (sb_scatter_done_valid)
        sbm_cnt[sb_scatter_done_parent_id[7:0]] <= sbm_cnt[sb_scatter_done_parent_id[7:0]] - 16'd1;
    end
  end
  assign sb_front_ready = (sbm_cnt[sb_query_node_id[7:0]] == 16'd0);

  always @(negedge clk) begin
    node_id_t e;
    if (!rst && disp_valid && disp_ready) begin
      disp_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL dispatch_unexpected: got node %0d, expected none", disp_node_id);
      end else begin
        e = exp_q.pop_front();
        if (disp_node_id !== e) $display("FAIL dispatch_order: got node %0d, expected %0d", disp_node_id, e);
        else passes++;
      end
    end
  end

  task automatic send_init(input node_id_t id, input child_cnt_t c);
    bit ok = 0;
    ld_node_id = id; ld_children_count = c; ld_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (ld_ready) ok = 1;
    end
    checks++;
    if (!ok) $display("FAIL init_accept: ld_ready got 0, expected 1 (node %0d)", id);
    else passes++;
    @(posedge clk); #1 ld_valid = 1'b0;
    exp_cnt[id[7:0]] = c;
    if (c == 0) exp_q.push_back(id);
    @(negedge clk);
    checks++;
    if (sb_init_valid !== 1'b1 || sb_init_node_id !== id || sb_init_children_count !== c)
      $display("FAIL init_s1: got v=%0b id=%0d cnt=%0d, expected v=1 id=%0d cnt=%0d",
               sb_init_valid, sb_init_node_id, sb_init_children_count, id, c);
    else passes++;
  endtask

  task automatic send_scatter(input int e, input node_id_t child, input node_id_t parent);
    bit ok = 0;
    logic [NS-1:0] m;
    m = 4'b0001 << e;
    sc_child_id[e*NW +: NW] = child; sc_parent_id[e*NW +: NW] = parent; sc_valid[e] = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (sc_ready[e]) ok = 1;
    end
    checks++;
    if (!ok || sc_ready !== m) $display("FAIL scatter_grant: got sc_ready=%b, expected %b", sc_ready, m);
    else passes++;
    @(posedge clk); #1 sc_valid[e] = 1'b0;
    exp_cnt[parent[7:0]] = exp_cnt[parent[7:0]] - 16'd1;
    if (exp_cnt[parent[7:0]] == 0) exp_q.push_back(parent);
    @(negedge clk);
    checks++;
    if (sb_scatter_done_valid !== 1'b1 || sb_scatter_done_child_id !== child ||
        sb_scatter_done_parent_id !== parent)
      $display("FAIL scatter_s1: got v=%0b c=%0d p=%0d, expected v=1 c=%0d p=%0d",
               sb_scatter_done_valid, sb_scatter_done_child_id, sb_scatter_done_parent_id, child, parent);
    else passes++;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 300 && (exp_q.size() != 0 || !idle); n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || !idle)
      $display("FAIL %s_drain: got %0d pending (idle=%0b), expected 0 (idle=1)", name, exp_q.size(), idle);
    else passes++;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 0; ld_node_id = 0; ld_children_count = 0;
    sc_valid = 0; sc_child_id = 0; sc_parent_id = 0; disp_ready = 1'b1;
    for (int i = 0; i < 256; i++) exp_cnt[i] = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_init_valid !== 0 || sb_scatter_done_valid !== 0)
      $display("FAIL reset_sb_valid: got %0b/%0b, expected 0/0", sb_init_valid, sb_scatter_done_valid);
    else passes++;
    checks++;
    if (sb_init_node_id !== 0 || sb_query_node_id !== 0 || sb_init_children_count !== 0)
      $display("FAIL reset_ids: got %0d/%0d/%0d, expected 0/0/0", sb_init_node_id, sb_query_node_id, sb_init_children_count);
    else passes++;
    checks++;
    if (disp_valid !== 0 || fifo_count !== 0 || idle !== 1)
      $display("FAIL reset_fifo: got dv=%0b cnt=%0d idle=%0b, expected 0/0/1", disp_valid, fifo_count, idle);
    else passes++;
    checks++;
    if (ld_ready !== 1 || sc_ready !== 0)
      $display("FAIL reset_ready: got ld=%0b sc=%b, expected 1/0000", ld_ready, sc_ready);
    else passes++;
  endtask

  task automatic test_init_latency();
    @(posedge clk); #1;
    ld_valid = 1; ld_node_id = 5; ld_children_count = 0;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1) $display("FAIL lat_accept: got %0b, expected 1", ld_ready); else passes++;
    @(posedge clk); #1 ld_valid = 0;
    exp_cnt[5] = 0; exp_q.push_back(16'd5);
    @(negedge clk);
    checks++;
    if (sb_init_valid !== 1 || sb_init_node_id !== 5)
      $display("FAIL lat_s1: got v=%0b id=%0d, expected 1/5", sb_init_valid, sb_init_node_id);
    else passes++;
    @(negedge clk);
    checks++;
    if (disp_valid !== 0 || sb_query_node_id !== 5 || sb_init_valid !== 0)
      $display("FAIL lat_s2: got dv=%0b q=%0d iv=%0b, expected 0/5/0", disp_valid, sb_query_node_id, sb_init_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (disp_valid !== 1 || disp_node_id !== 5)
      $display("FAIL lat_disp: got dv=%0b id=%0d, expected 1/5", disp_valid, disp_node_id);
    else passes++;
    wait_drain("lat");
  endtask

  task automatic test_dependency();
    int base = disp_seen;
    send_init(16'd7, 16'd2);
    send_scatter(0, 16'd3, 16'd7);
    send_scatter(2, 16'd4, 16'd7);
    wait_drain("dep");
    repeat (4) @(negedge clk);
    checks++;
    if (disp_seen - base !== 1) $display("FAIL dep_count: got %0d dispatches, expected 1", disp_seen - base);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [NS-1:0] m;
    do_reset();
    for (int k = 0; k < 5; k++) send_init(node_id_t'(20 + k), 16'd1);
    wait_drain("rr_init");
    @(posedge clk); #1;
    for (int e = 0; e < NS; e++) begin
      sc_parent_id[e*NW +: NW] = node_id_t'(20 + e);
      sc_child_id[e*NW +: NW]  = node_id_t'(100 + e);
    end
    sc_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m = 4'b0001 << (k % NS);
      checks++;
      if (sc_ready !== m) $display("FAIL rr_order_%0d: got %b, expected %b", k, sc_ready, m);
      else passes++;
      @(posedge clk); #1;
      exp_cnt[20 + k] = exp_cnt[20 + k] - 16'd1;
      if (exp_cnt[20 + k] == 0) exp_q.push_back(node_id_t'(20 + k));
      sc_parent_id[(k % NS)*NW +: NW] = node_id_t'(24 + k);
      if (k == 4) sc_valid = '0;
    end
    wait_drain("rr");
  endtask

  task automatic test_priority();
    int grants = 0;
    send_init(16'd30, 16'd4);
    @(posedge clk); #1;
    for (int e = 0; e < NS; e++) begin
      sc_parent_id[e*NW +: NW] = 16'd30;
      sc_child_id[e*NW +: NW]  = node_id_t'(200 + e);
    end
    ld_valid = 1; ld_node_id = 31; ld_children_count = 0; sc_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1 || sc_ready !== 0)
      $display("FAIL prio_loader: got ld=%0b sc=%b, expected 1/0000", ld_ready, sc_ready);
    else passes++;
    @(posedge clk); #1 ld_valid = 0;
    exp_cnt[31] = 0; exp_q.push_back(16'd31);
    for (int n = 0; n < 20 && sc_valid != 0; n++) begin
      logic [NS-1:0] g;
      @(negedge clk);
      g = sc_ready;
      checks++;
      if (!$onehot(g) || (g & ~sc_valid) != 0)
        $display("FAIL prio_grant: got %b, expected one-hot within %b", g, sc_valid);
      else passes++;
      @(posedge clk); #1;
      if ($onehot(g)) begin
        sc_valid = sc_valid & ~g;
        grants++;
        exp_cnt[30] = exp_cnt[30] - 16'd1;
        if (exp_cnt[30] == 0) exp_q.push_back(16'd30);
      end
    end
    checks++;
    if (grants !== 4) $display("FAIL prio_all_engines: got %0d grants, expected 4", grants); else passes++;
    sc_valid = '0;
    wait_drain("prio");
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bit over = 0;
    disp_ready = 0;
    @(posedge clk); #1;
    ld_valid = 1; ld_node_id = 40; ld_children_count = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_count > 16) over = 1;
      if (ld_ready) begin acc++; exp_cnt[ld_node_id[7:0]] = 0; exp_q.push_back(ld_node_id); end
      @(posedge clk); #1 ld_node_id = node_id_t'(40 + acc);
    end
    @(negedge clk);
    checks++;
    if (acc !== 16) $display("FAIL bp_accepted: got %0d, expected 16", acc); else passes++;
    checks++;
    if (fifo_count !== 16 || ld_ready !== 0 || sc_ready !== 0)
      $display("FAIL bp_stall: got cnt=%0d ld=%0b sc=%b, expected 16/0/0000", fifo_count, ld_ready, sc_ready);
    else passes++;
    checks++;
    if (disp_valid !== 1 || disp_node_id !== 40)
      $display("FAIL bp_hold: got dv=%0b id=%0d, expected 1/40", disp_valid, disp_node_id);
    else passes++;
    disp_ready = 1;
    for (int c = 0; c < 60 && acc < 20; c++) begin
      @(negedge clk);
      if (fifo_count > 16) over = 1;
      if (ld_ready) begin acc++; exp_cnt[ld_node_id[7:0]] = 0; exp_q.push_back(ld_node_id); end
      @(posedge clk); #1 ld_node_id = node_id_t'(40 + acc);
      if (acc == 20) ld_valid = 0;
    end
    ld_valid = 0;
    checks++;
    if (acc !== 20 || over) $display("FAIL bp_resume: got acc=%0d over=%0b, expected 20/0", acc, over);
    else passes++;
    wait_drain("bp");
  endtask

  task automatic test_reset_midflight();
    int acc = 0;
    disp_ready = 0;
    @(posedge clk); #1;
    ld_valid = 1; ld_node_id = 60; ld_children_count = 0;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      @(negedge clk);
      if (ld_ready) acc++;
      @(posedge clk); #1 ld_node_id = node_id_t'(60 + acc);
      if (acc == 5) ld_valid = 0;
    end
    ld_valid = 0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3 || sb_init_valid !== 1 || idle !== 0)
      $display("FAIL mid_pre: got cnt=%0d iv=%0b idle=%0b, expected 3/1/0", fifo_count, sb_init_valid, idle);
    else passes++;
    #1 rst = 1;
    #1;
    checks++;
    if (fifo_count !== 0 || disp_valid !== 0 || sb_init_valid !== 0 || sb_query_node_id !== 0 || idle !== 1)
      $display("FAIL mid_reset: got cnt=%0d dv=%0b iv=%0b q=%0d idle=%0b, expected 0/0/0/0/1",
               fifo_count, disp_valid, sb_init_valid, sb_query_node_id, idle);
    else passes++;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (idle !== 1 || fifo_count !== 0)
      $display("FAIL mid_release: got idle=%0b cnt=%0d, expected 1/0", idle, fifo_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_init_latency();
    test_dependency();
    test_round_robin();
    test_priority();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
